// File: rtl/maxnet_pkg.sv
// rtl/maxnet_pkg.sv - shared state encoding and helpers for the MaxNet sequencer
package maxnet_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_CHECK = 3'd2,
    S_WAIT  = 3'd3,
    S_LOAD  = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  // Callers zero-extend their vector into 32 bits, so N_NEURONS must stay <= 32.
  function automatic int popcount(input logic [31:0] v);
    int cnt;
    cnt = 0;
    for (int i = 0; i < 32; i++) begin
      cnt += int'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/maxnet_winner_enc.sv
// rtl/maxnet_winner_enc.sv - counts nonzero activations and encodes the lowest nonzero index
module maxnet_winner_enc
  import maxnet_pkg::*;
#(
  parameter int N_NEURONS = 4,
  parameter int IDX_W     = 2
) (
  input  logic [N_NEURONS-1:0] nonzero_i,
  output logic                 nz_zero_o,
  output logic                 nz_one_o,
  output logic [IDX_W-1:0]     idx_o
);

  int nz_cnt;

  always_comb begin
    nz_cnt    = popcount(32'(nonzero_i));
    nz_zero_o = (nz_cnt == 0);
    nz_one_o  = (nz_cnt == 1);
  end

  // Scan downward so the lowest set index is the one left standing.
  always_comb begin
    idx_o = '0;
    for (int i = N_NEURONS - 1; i >= 0; i--) begin
      if (nonzero_i[i]) begin
        idx_o = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/maxnet_controller.sv
// rtl/maxnet_controller.sv - sequences init load, datapath waits and reloads until one winner remains
module maxnet_controller
  import maxnet_pkg::*;
#(
  parameter int N_NEURONS = 4,
  parameter int DP_LAT    = 2,
  parameter int MAX_ITER  = 255,
  parameter int ITER_W    = 8,
  parameter int IDX_W     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [N_NEURONS-1:0] zero_flags,
  output logic                 ld_init,
  output logic                 ld_a,
  output logic                 busy,
  output logic                 done,
  output logic                 winner_valid,
  output logic [IDX_W-1:0]     winner_idx,
  output logic                 timeout,
  output logic [ITER_W-1:0]    iter_count
);

  localparam int WAIT_W = (DP_LAT > 1) ? $clog2(DP_LAT) : 1;

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [ITER_W-1:0]   iter_q, iter_d;
  logic                valid_q, valid_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                timeout_q, timeout_d;

  logic                nz_zero, nz_one;
  logic [IDX_W-1:0]    enc_idx;

  maxnet_winner_enc #(
    .N_NEURONS (N_NEURONS),
    .IDX_W     (IDX_W)
  ) u_winner_enc (
    .nonzero_i (~zero_flags),
    .nz_zero_o (nz_zero),
    .nz_one_o  (nz_one),
    .idx_o     (enc_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wait_q    <= '0;
      iter_q    <= '0;
      valid_q   <= 1'b0;
      idx_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      iter_q    <= iter_d;
      valid_q   <= valid_d;
      idx_q     <= idx_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    iter_d    = iter_q;
    valid_d   = valid_q;
    idx_d     = idx_q;
    timeout_d = timeout_q;

    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d   = S_INIT;
          iter_d    = '0;
          valid_d   = 1'b0;
          idx_d     = '0;
          timeout_d = 1'b0;
        end
      end
      S_INIT: state_d = S_CHECK;
      S_CHECK: begin
        if (nz_zero || nz_one) begin
          state_d = S_DONE;
          valid_d = nz_one;
          idx_d   = nz_one ? enc_idx : '0;
        end else if (iter_q == ITER_W'(MAX_ITER)) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
          valid_d   = 1'b0;
          idx_d     = '0;
        end else begin
          state_d = S_WAIT;
          wait_d  = WAIT_W'(DP_LAT - 1);
        end
      end
      S_WAIT: begin
        if (wait_q == '0) begin
          state_d = S_LOAD;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      S_LOAD: begin
        state_d = S_CHECK;
        if (iter_q != ITER_W'(MAX_ITER)) begin
          iter_d = iter_q + 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort outranks every transition above and discards the partial result.
    if (abort && state_q != S_IDLE) begin
      state_d   = S_IDLE;
      wait_d    = '0;
      iter_d    = '0;
      valid_d   = 1'b0;
      idx_d     = '0;
      timeout_d = 1'b0;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign ld_init      = (state_q == S_INIT) && !abort;
  assign ld_a         = (state_q == S_LOAD) && !abort;
  assign done         = (state_q == S_DONE) && !abort;
  assign winner_valid = valid_q;
  assign winner_idx   = idx_q;
  assign timeout      = timeout_q;
  assign iter_count   = iter_q;

endmodule
